// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction ROM and buffers {pc, instr} in a prefetch queue.
// A fetched word is visible one cycle later; a full queue stalls fetch unless the head pops in the same cycle.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 1024,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);

  localparam int          PW      = $clog2(QDEPTH);
  localparam logic [PW:0] QD      = (PW+1)'(QDEPTH);
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

  typedef enum logic {ST_RUN, ST_FAULT} state_e;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [PW:0] head_q, head_d;
  logic [PW:0] tail_q, tail_d;
  logic [63:0] q_pc_q    [QDEPTH];
  logic [63:0] q_pc_d    [QDEPTH];
  logic [31:0] q_instr_q [QDEPTH];
  logic [31:0] q_instr_d [QDEPTH];

  logic [PW:0] count;
  logic        pc_legal;
  logic        pop;
  logic        can_enq;
  logic        enq;

  // Comparing against the last legal word address avoids the wrap of fetch_pc+3.
  assign pc_legal  = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q <= LAST_PC);
  assign count     = tail_q - head_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign can_enq   = (state_q == ST_RUN) && !redirect && ((count < QD) || pop);
  assign enq       = can_enq && pc_legal;

  assign imem_addr = ((state_q == ST_RUN) && pc_legal) ? fetch_pc_q : 64'd0;
  assign out_pc    = out_valid ? q_pc_q[head_q[PW-1:0]] : 64'd0;
  assign out_instr = out_valid ? q_instr_q[head_q[PW-1:0]] : 32'd0;
  assign fault     = (state_q == ST_FAULT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;

    if (redirect) begin
      // Flush: a pop taken in this cycle is simply discarded with the rest.
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (enq) begin
        q_pc_d[tail_q[PW-1:0]]    = fetch_pc_q;
        q_instr_d[tail_q[PW-1:0]] = imem_instr;
        tail_d                    = tail_q + 1'b1;
        fetch_pc_d                = fetch_pc_q + 64'd4;
      end
      if ((state_q == ST_RUN) && !pc_legal) begin
        state_d = ST_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      q_pc_q     <= '{default: '0};
      q_instr_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      q_pc_q     <= q_pc_d;
      q_instr_q  <= q_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fetch_sequencer;

  localparam logic [63:0] RESET_PC  = 64'd0;
  localparam int          MEM_BYTES = 1024;
  localparam int          QDEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;

  logic [31:0] rom [0:255];
  assign imem_instr = rom[imem_addr[9:2]];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .MEM_BYTES(MEM_BYTES),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .fault      (fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an ordered list of fetched entries, a PC and a fault flag.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc    = RESET_PC;
  bit          m_fault = 1'b0;

  function automatic bit m_legal(input logic [63:0] pc);
    logic [64:0] last_byte;
    last_byte = {1'b0, pc} + 65'd3;
    return (pc % 64'd4 == 64'd0) && (last_byte < 65'(MEM_BYTES));
  endfunction

  function automatic logic [63:0] m_out_pc();
    return (mq.size() > 0) ? mq[0].pc : 64'd0;
  endfunction

  function automatic logic [31:0] m_out_instr();
    return (mq.size() > 0) ? mq[0].instr : 32'd0;
  endfunction

  function automatic logic [63:0] m_imem();
    return (!m_fault && m_legal(m_pc)) ? m_pc : 64'd0;
  endfunction

  task automatic model_update(input logic rst, input logic redir, input logic [63:0] rpc, input logic rdy);
    ent_t e;
    if (rst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else if (redir) begin
      mq.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (!m_fault) begin
        if (!m_legal(m_pc)) begin
          m_fault = 1'b1;
        end else if (mq.size() < QDEPTH) begin
          e.pc    = m_pc;
          e.instr = rom[m_pc[9:2]];
          mq.push_back(e);
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and land 1ns after the edge.
  task automatic step(input logic rst, input logic redir, input logic [63:0] rpc, input logic rdy);
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = rdy;
    model_update(rst, redir, rpc, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 64'd200, 1'b1);
    n_tests++;
    if ({out_valid, out_pc, out_instr, fault} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b pc=%0h instr=%0h fault=%0b, want all zero", out_valid, out_pc, out_instr, fault);
    end
    n_tests++;
    if (imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_imem_addr: got %0h want %0h", imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    step(1'b1, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4*i) || out_instr !== rom[i]) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: got v=%0b pc=%0h instr=%0h want v=1 pc=%0h instr=%0h",
                 i, out_valid, out_pc, out_instr, 4*i, rom[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b0, 64'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 64'd0, 1'b0);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0 || imem_addr !== ((k == 1) ? 64'd4 : 64'd8)) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%0b pc=%0h imem=%0h want v=1 pc=0 imem=%0h",
                 k, out_valid, out_pc, imem_addr, (k == 1) ? 4 : 8);
      end
    end
    for (int j = 1; j <= 3; j++) begin
      step(1'b0, 1'b0, 64'd0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4*j) || out_instr !== rom[j]) begin
        n_fail++;
        $display("FAIL resume[%0d]: got v=%0b pc=%0h instr=%0h want pc=%0h instr=%0h",
                 j, out_valid, out_pc, out_instr, 4*j, rom[j]);
      end
    end
  endtask

  task automatic test_redirect_full();
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    n_tests++;
    if (out_pc !== 64'd8 || imem_addr !== 64'd16) begin
      n_fail++;
      $display("FAIL full_before_redirect: got pc=%0h imem=%0h want pc=8 imem=10", out_pc, imem_addr);
    end
    step(1'b0, 1'b1, 64'd40, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%0b pc=%0h want v=0 pc=0", out_valid, out_pc);
    end
    step(1'b0, 1'b0, 64'd0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'd40 || out_instr !== rom[10]) begin
      n_fail++;
      $display("FAIL redirect_target: got v=%0b pc=%0h instr=%0h want pc=28 instr=%0h",
               out_valid, out_pc, out_instr, rom[10]);
    end
  endtask

  task automatic test_bounds();
    step(1'b0, 1'b1, 64'd1008, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b1);
      n_tests++;
      if (i < 4) begin
        if (out_valid !== 1'b1 || out_pc !== 64'(1008 + 4*i) || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL bounds_deliver[%0d]: got v=%0b pc=%0d fault=%0b want v=1 pc=%0d fault=0",
                   i, out_valid, out_pc, fault, 1008 + 4*i);
        end
      end else if (out_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 64'd0) begin
        n_fail++;
        $display("FAIL bounds_halt[%0d]: got v=%0b fault=%0b imem=%0h want v=0 fault=1 imem=0",
                 i, out_valid, fault, imem_addr);
      end
    end
  endtask

  task automatic test_fault_drain();
    step(1'b0, 1'b1, 64'd1016, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    n_tests++;
    if (fault !== 1'b1 || out_valid !== 1'b1 || out_pc !== 64'd1016 || imem_addr !== 64'd0) begin
      n_fail++;
      $display("FAIL drain_hold: got fault=%0b v=%0b pc=%0d imem=%0h want fault=1 v=1 pc=1016 imem=0",
               fault, out_valid, out_pc, imem_addr);
    end
    step(1'b0, 1'b0, 64'd0, 1'b1);
    n_tests++;
    if (fault !== 1'b1 || out_valid !== 1'b1 || out_pc !== 64'd1020) begin
      n_fail++;
      $display("FAIL drain_next: got fault=%0b v=%0b pc=%0d want fault=1 v=1 pc=1020", fault, out_valid, out_pc);
    end
    step(1'b0, 1'b0, 64'd0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got v=%0b fault=%0b want v=0 fault=1", out_valid, fault);
    end
  endtask

  task automatic test_fault_recovery();
    step(1'b0, 1'b1, 64'd4, 1'b1);
    n_tests++;
    if (fault !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 64'd4) begin
      n_fail++;
      $display("FAIL recover_clear: got fault=%0b v=%0b imem=%0h want fault=0 v=0 imem=4", fault, out_valid, imem_addr);
    end
    for (int j = 1; j <= 2; j++) begin
      step(1'b0, 1'b0, 64'd0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4*j) || out_instr !== rom[j]) begin
        n_fail++;
        $display("FAIL recover_fetch[%0d]: got v=%0b pc=%0h instr=%0h want pc=%0h instr=%0h",
                 j, out_valid, out_pc, out_instr, 4*j, rom[j]);
      end
    end
    step(1'b0, 1'b1, 64'd6, 1'b1);
    n_tests++;
    if (fault !== 1'b0 || imem_addr !== 64'd0) begin
      n_fail++;
      $display("FAIL misalign_addr: got fault=%0b imem=%0h want fault=0 imem=0", fault, imem_addr);
    end
    step(1'b0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    n_tests++;
    if (fault !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_fault: got fault=%0b v=%0b want fault=1 v=0", fault, out_valid);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    n_tests++;
    if (imem_addr !== 64'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_addr: got imem=%0h fault=%0b want imem=0 fault=0", imem_addr, fault);
    end
    step(1'b0, 1'b0, 64'd0, 1'b1);
    n_tests++;
    if (fault !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_fault: got fault=%0b v=%0b want fault=1 v=0", fault, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 1'b1, 64'd100, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 64'd200, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL midreset_state: got v=%0b fault=%0b imem=%0h want v=0 fault=0 imem=%0h",
               out_valid, fault, imem_addr, RESET_PC);
    end
    step(1'b0, 1'b0, 64'd0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== rom[0]) begin
      n_fail++;
      $display("FAIL midreset_resume: got v=%0b pc=%0h instr=%0h want v=1 pc=0 instr=%0h",
               out_valid, out_pc, out_instr, rom[0]);
    end
  endtask

  task automatic test_random();
    logic        rst, redir, rdy;
    logic [63:0] rpc;
    int          sel;
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom % 100) == 0;
      redir = ($urandom % 10) == 0;
      rdy   = ($urandom % 4) != 0;
      sel   = $urandom % 8;
      rpc   = 64'($urandom_range(0, 1023));
      if (sel < 5) rpc[1:0] = 2'b00;
      else if (sel == 5) rpc[0] = 1'b1;
      else if (sel == 6) rpc = 64'd1024 + 64'(4 * $urandom_range(0, 8));
      else rpc = {$urandom, $urandom} & ~64'd3;
      step(rst, redir, rpc, rdy);
      n_tests++;
      if ({out_valid, out_pc, out_instr, fault, imem_addr} !==
          {mq.size() > 0, m_out_pc(), m_out_instr(), m_fault, m_imem()}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b pc=%0h instr=%0h fault=%0b imem=%0h want v=%0b pc=%0h instr=%0h fault=%0b imem=%0h",
                 c, out_valid, out_pc, out_instr, fault, imem_addr,
                 mq.size() > 0, m_out_pc(), m_out_instr(), m_fault, m_imem());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_bounds();
    test_fault_recovery();
    test_fault_drain();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the single-cycle ARM core. It owns the program counter, drives the byte address into the combinational instruction ROM, and buffers fetched words with their PCs in a small prefetch queue. Downstream decode pops the queue through a valid/ready handshake. The block handles branch redirects by flushing the queue, and halts fetching with a fault flag on any misaligned or out-of-bounds PC, so the ROM never sees an illegal address.

## Interface
- RESET_PC, 64'd0: PC loaded on reset.
- MEM_BYTES, 1024: ROM size in bytes. Must be a power of two and greater than 4.
- QDEPTH, 2: prefetch queue entries. Must be a power of two and at least 2.

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_addr  out  64  byte address to the instruction ROM (combinational from state)
- imem_instr  in  32  ROM read data for imem_addr, valid in the same cycle
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  64  new fetch target
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  consumer accepts the head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  64  byte address of the head instruction
- fault  out  1  fetch halted on a bad PC; cleared only by redirect or reset

## Operation
- State: fetch_pc (64 bits), queue storage of {pc, instr} entries, head/tail pointers of log2(QDEPTH)+1 bits, and a 2-state FSM (RUN, FAULT).
- The PC is legal when fetch_pc[1:0]==0 and fetch_pc+3 < MEM_BYTES. Evaluate this as a 64-bit unsigned compare, with no wrap.
- pop = out_valid & out_ready.
- can_enq = state==RUN & !redirect & (count<QDEPTH | pop).
- In RUN with a legal PC and can_enq:
  - write {fetch_pc, imem_instr} at the tail;
  - fetch_pc <= fetch_pc+4.
- In RUN with an illegal PC and !redirect:
  - no enqueue;
  - the state moves to FAULT and fetch_pc holds.
- In FAULT:
  - no fetches;
  - the queue still drains normally;
  - fault=1.
- imem_addr = fetch_pc in RUN when the PC is legal, otherwise 64'd0. The ROM's alignment and bounds checks therefore never fire.
- Redirect has priority over everything:
  - the queue is flushed (count <= 0) at the edge;
  - fetch_pc <= redirect_pc;
  - the state moves to RUN, even from FAULT;
  - no enqueue happens in the redirect cycle.
- A pop in the redirect cycle is a completed handshake. The consumer has taken that head entry, and it is lost from the queue anyway because of the flush.
- Pop and enqueue in the same cycle with the queue full: both happen and count stays at QDEPTH.
- Pop with the queue empty is impossible, because out_valid=0.
- out_instr and out_pc come from the head entry. They read 0 while out_valid=0.
- fetch_pc+4 wraps modulo 2^64 without special handling. The legality check catches the result before it is used.

## Timing
- Reset values:
  - fetch_pc=RESET_PC;
  - the queue is empty;
  - state=RUN;
  - out_valid=0, out_instr=0, out_pc=0, fault=0;
  - imem_addr=RESET_PC, or 0 if RESET_PC is illegal.
- Fetch latency: a word fetched in cycle N is visible on out_valid/out_instr in cycle N+1. The first instruction appears in the first cycle after the edge at which reset deasserts.
- Steady-state throughput is one instruction per cycle when out_ready is held high.
- After a redirect, the target instruction appears 2 cycles after the cycle in which redirect was high: the flush edge, then the fetch edge.
- fault rises the cycle after the illegal PC is first evaluated in RUN.
- reset asserted mid-operation returns every register to its reset value at the next edge. Reset overrides redirect.

## Test plan
- Sequential fetch:
  - Stimulus: reset with RESET_PC=0, ROM words 0..3 = A,B,C,D, out_ready=1.
  - Required response: out_pc reads 0,4,8,12 with out_instr A,B,C,D on consecutive cycles, starting 1 cycle after reset falls.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles, then 1.
  - Required response: count saturates at QDEPTH=2, out_pc stays 0 while stalled, then the sequence continues 0,4,8 with no skipped or duplicated PC.
- Redirect with the queue full:
  - Stimulus: queue holds PCs 8 and 12, then redirect=1 with redirect_pc=40.
  - Required response: the next cycle has out_valid=0; the cycle after has out_pc=40 and out_instr=mem[10].
- Bounds fault:
  - Stimulus: MEM_BYTES=16, run sequentially.
  - Required response: PCs 0,4,8,12 are delivered; fault=1 once fetch_pc=16; imem_addr=0 from then on; the queue drains; no further out_valid.
- Fault recovery and misalignment:
  - Stimulus: while faulted, redirect to 4. Later, redirect to 6.
  - Required response: redirect to 4 clears fault and delivers 4,8. Redirect to 6 gives fault=1 with no enqueue.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle while the queue holds 2 entries and a redirect is pending.
  - Required response: out_valid=0 and fault=0 after the edge, and fetch resumes from RESET_PC.
